// File: rtl/key_pkg.sv
// Shared constants for the push-button debounce path.
// Key levels are active-low: 1 means released.
package key_pkg;

   localparam logic KEY_RELEASED = 1'b1;
   localparam int   DEBOUNCE_20MS_50MHZ = 1_000_000;

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchroniser, stability counter,
// registered debounced level and press/release pulses.
module key_debounce_cell
   import key_pkg::*;
#(
   parameter int STABLE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_db,
   output logic key_press,
   output logic key_release
);

   localparam int CW = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;
   logic          differs;
   logic          expired;

   assign differs = (sync2 != key_db);
   assign expired = (cnt == CNT_MAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= KEY_RELEASED;
         sync2 <= KEY_RELEASED;
      end else begin
         sync1 <= key_raw;
         sync2 <= sync1;
      end
   end

   // Any cycle matching the current state discards progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt         <= '0;
         key_db      <= KEY_RELEASED;
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         if (!differs) begin
            cnt <= '0;
         end else if (expired) begin
            cnt         <= '0;
            key_db      <= sync2;
            key_press   <= (sync2 != KEY_RELEASED);
            key_release <= (sync2 == KEY_RELEASED);
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Per-key debouncer for the board push-buttons.
// Wiring only: one independent cell per key.
module key_debounce
   import key_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter int STABLE_CYCLES = DEBOUNCE_20MS_50MHZ
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_db,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      key_debounce_cell #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_cell (
         .clk        (clk),
         .reset      (reset),
         .key_raw    (key_raw[i]),
         .key_db     (key_db[i]),
         .key_press  (key_press[i]),
         .key_release(key_release[i])
      );
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Per-key debouncer for the DE2-115 push-buttons, sitting directly upstream of the key PIO slave in the NIOS core. It synchronises the raw asynchronous KEY pins and filters contact bounce. It presents a stable, same-polarity key vector to the PIO `in_port`. It also produces one-cycle press/release pulses for local fabric logic.

## Interface
- `N_KEYS`, default 4: number of keys; 1..32.
- `STABLE_CYCLES`, default 1_000_000: cycles a synchronised input must differ from the debounced state before that state is updated (20 ms at 50 MHz). Minimum 2.
- `clk` input 1: system clock (50 MHz board clock).
- `reset` input 1: one clock; reset is synchronous and active-high.
- `key_raw` input `N_KEYS`: raw KEY pins, asynchronous, active-low (0 = pressed).
- `key_db` output `N_KEYS`: debounced key state, active-low, registered; drives PIO `in_port`.
- `key_press` output `N_KEYS`: one-cycle pulse per bit when `key_db` bit goes 1→0.
- `key_release` output `N_KEYS`: one-cycle pulse per bit when `key_db` bit goes 0→1.

## Operation
- Keys are fully independent; per key there is one 2-FF synchroniser (`sync1`→`sync2`), one stability counter and one `key_db` bit.
- Each cycle, where `sync2 != key_db`:
  - if `cnt == STABLE_CYCLES-1`, then `key_db <= sync2` and `cnt <= 0`, and the matching press/release pulse is asserted;
  - else `cnt <= cnt + 1`.
- Each cycle, where `sync2 == key_db`: `cnt <= 0`. Any bounce back restarts the count; there is no partial credit.
- Pulses are registered and asserted in the same cycle `key_db` shows the new value. They are deasserted the following cycle.
- Counter width is `$clog2(STABLE_CYCLES)`. The counter never exceeds `STABLE_CYCLES-1`, so no wrap-around occurs.
- Reset values:
  - `sync1`, `sync2`, `key_db`: all ones (released);
  - `cnt`: 0;
  - `key_press`, `key_release`: 0.
- Reset has priority over all other updates. Reset asserted mid-count discards the count. After release a full count is required again.
- Keys held pressed through reset are reported as a press (`key_press` pulse) one full latency after reset deasserts.
- Simultaneous transitions on several keys update their bits in the same cycle, and the pulse vector has multiple bits set.

## Timing
- Latency:
  - raw transition sampled at edge 0 reaches `sync2` at edge 1;
  - `key_db` changes at edge `STABLE_CYCLES+1`, i.e. `STABLE_CYCLES+2` rising edges after the raw change is present before an edge;
  - this counts synchroniser plus filter.
- Minimum accepted stable level: `STABLE_CYCLES` consecutive cycles at `sync2`. `STABLE_CYCLES-1` cycles is rejected.
- Throughput: a new transition can begin counting the cycle after `key_db` updates.
- All outputs are registered. There is no combinational path from `key_raw` to any output.
- `key_raw` is the only asynchronous input and passes only through `sync1`.

## Structure
- Shared package `key_pkg`:
  - `KEY_RELEASED` level constant (1'b1);
  - `DEBOUNCE_20MS_50MHZ` = 1_000_000, used as the default.
- Natural sub-module `key_debounce_cell`: one key (synchroniser, counter, state bit, pulses). It is instantiated `N_KEYS` times in a generate loop in `key_debounce`.
- The top level is wiring only.

## Test plan
All scenarios use `N_KEYS=4`, `STABLE_CYCLES=16`; cycle 0 = first edge with the new `key_raw`.

1. **Reset defaults**: hold `reset`=1 for 3 cycles with `key_raw`=4'hF → `key_db`=4'hF, `key_press`=`key_release`=0. Then drive `key_raw`=4'h0 and release reset → `key_db`=4'h0 and `key_press`=4'hF for exactly one cycle, 18 edges later.
2. **Clean press/release**: `key_raw` 4'hF→4'hE at cycle 0 → `key_db`=4'hE and `key_press`=4'h1 at edge 17 only. Return to 4'hF → `key_release`=4'h1 after the same latency.
3. **Bounce**: toggle `key_raw[1]` every 5 cycles for 60 cycles, then hold 0 → `key_db` stays 4'hF throughout the bounce. `key_db[1]` falls 18 edges after the last toggle; exactly one `key_press` pulse.
4. **Threshold boundary**: `key_raw[2]` low for 15 cycles → no change, no pulse. Low for 16 cycles → `key_db[2]` falls, one pulse, then rises again after release latency.
5. **Simultaneous keys**: `key_raw` 4'hF→4'h3 in one cycle → `key_db`=4'h3 and `key_press`=4'hC in the same single cycle.
6. **Reset mid-count**: press key 0, assert `reset` at cycle 10 for 2 cycles while still pressed → `key_db` remains 4'hF through reset. After reset release, `key_db[0]` falls exactly 18 edges later.
